system_irq_aggregator: RTL

Avalon-MM slave that collects up to 16 peripheral interrupt lines, including the system clock timer's `irq`, into one registered CPU interrupt. It sits downstream of the timer and the other peripherals and upstream of the Nios II IRQ input. Per source it provides 2-flop synchronisation, level/edge capture, a pending latch, an enable mask and software trigger, plus a lowest-index-first vector register for fast dispatch.

---
 rtl/system_irq_aggregator.sv | 115 +++++++++++
 1 files changed

// File: rtl/system_irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source 2-flop sync, level/edge capture,
// pending latch with enable mask and software trigger, lowest-index vector.
module system_irq_aggregator #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] ADDR_MODE    = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [2:0] ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] ADDR_SWSET   = 3'd5;

    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;
    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] mode;

    logic               wr_en;
    logic [NUM_IRQ-1:0] wdata_src;
    logic [NUM_IRQ-1:0] ack_vec;
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] active;
    logic               vec_valid;
    logic [3:0]         vec_idx;
    logic [15:0]        readdata_nxt;
    logic               unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata_src    = writedata[NUM_IRQ-1:0];
    assign active       = pending & enable;
    assign unused_wdata = ^writedata;

    // Ack decode only covers existing sources, so out-of-range indices fall away.
    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_vec[i] = wr_en && (address == ADDR_VECTOR) && (writedata[3:0] == 4'(i));
        end
    end

    always_comb begin
        set_vec = (sync2 & ~prev)
                | ((wr_en && address == ADDR_SWSET) ? wdata_src : '0);
        clr_vec = ((wr_en && address == ADDR_PENDING) ? wdata_src : '0)
                | ack_vec;
        // Edge sources: set dominates clear; level sources simply track sync2.
        pending_nxt = (mode & (set_vec | (pending & ~clr_vec)))
                    | (~mode & sync2);
    end

    always_comb begin
        vec_valid = 1'b0;
        vec_idx   = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                vec_valid = 1'b1;
                vec_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        readdata_nxt = '0;
        case (address)
            ADDR_PENDING: readdata_nxt[NUM_IRQ-1:0] = pending;
            ADDR_ENABLE:  readdata_nxt[NUM_IRQ-1:0] = enable;
            ADDR_MODE:    readdata_nxt[NUM_IRQ-1:0] = mode;
            ADDR_ACTIVE:  readdata_nxt[NUM_IRQ-1:0] = active;
            ADDR_VECTOR:  readdata_nxt = vec_valid ? {1'b1, 11'd0, vec_idx} : 16'd0;
            default:      readdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            pending  <= '0;
            enable   <= '0;
            mode     <= '0;
            readdata <= '0;
            irq_out  <= 1'b0;
        end else begin
            sync1    <= irq_in;
            sync2    <= sync1;
            prev     <= sync2;
            pending  <= pending_nxt;
            readdata <= readdata_nxt;
            irq_out  <= |active;
            if (wr_en && address == ADDR_ENABLE) begin
                enable <= wdata_src;
            end
            if (wr_en && address == ADDR_MODE) begin
                mode <= wdata_src;
            end
        end
    end

endmodule
